// File: rtl/matvec_result_collector_pkg.sv
// Shared definitions for the matrix-vector result collector: Q-format constants,
// FSM state encoding and the round/saturate helper.
package matvec_result_collector_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;

  localparam logic [3:0] IDLE_ENC    = 4'b0001;
  localparam logic [3:0] COLLECT_ENC = 4'b0010;
  localparam logic [3:0] DRAIN_ENC   = 4'b0100;
  localparam logic [3:0] DONE_ENC    = 4'b1000;

  typedef enum logic [3:0] {
    IDLE    = IDLE_ENC,
    COLLECT = COLLECT_ENC,
    DRAIN   = DRAIN_ENC,
    DONE    = DONE_ENC
  } state_t;

  // Round half-up, drop frac bits, clamp to a signed width-bit range.
  function automatic logic signed [63:0] sat_round(
    input  logic signed [63:0] value,
    input  int                 frac,
    input  int                 width,
    output logic               sat
  );
    logic signed [63:0] rounded;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    rounded = (frac > 0) ? ((value + (64'sd1 <<< (frac - 1))) >>> frac) : value;
    max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (width - 1));
    sat     = 1'b0;
    if (rounded > max_v) begin
      rounded = max_v;
      sat     = 1'b1;
    end else if (rounded < min_v) begin
      rounded = min_v;
      sat     = 1'b1;
    end
    return rounded;
  endfunction

endpackage

// File: rtl/matvec_result_collector_round.sv
// Combinational fixed-point round-and-saturate stage; reusable by later
// activation stages that narrow wide accumulators to element width.
module fxp_round_sat #(
  parameter int IN_WIDTH  = 34,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic signed [IN_WIDTH-1:0]  value_in,
  output logic        [OUT_WIDTH-1:0] value_out,
  output logic                        sat
);
  import matvec_result_collector_pkg::*;

  always_comb begin
    sat       = 1'b0;
    value_out = OUT_WIDTH'(sat_round(64'(value_in), FRAC_BITS, OUT_WIDTH, sat));
  end

endmodule

// File: rtl/matvec_result_collector.sv
// Collects per-row dot products, adds bias, rounds/saturates into an output
// buffer and streams the vector out in BANDWIDTH-lane chunks.
module matvec_result_collector #(
  parameter int MAX_ROWS   = 64,
  parameter int BANDWIDTH  = 16,
  parameter int DATA_WIDTH = matvec_result_collector_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = matvec_result_collector_pkg::FRAC_BITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(MAX_ROWS):0]       num_rows,
  input  logic                            bias_write_enable,
  input  logic [$clog2(MAX_ROWS)-1:0]     bias_base_addr,
  input  logic [DATA_WIDTH*BANDWIDTH-1:0] bias_in,
  input  logic [2*DATA_WIDTH-1:0]         result_in,
  input  logic                            result_valid_in,
  output logic [DATA_WIDTH*BANDWIDTH-1:0] out_data,
  output logic [$clog2(MAX_ROWS)-1:0]     out_base_addr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            sat_flag
);
  import matvec_result_collector_pkg::*;

  localparam int AW = $clog2(MAX_ROWS);
  localparam int RW = AW + 1;
  localparam int SW = 2 * DATA_WIDTH + 2;

  state_t                          state, next_state;
  logic [RW-1:0]                   row_cnt, rows_total;
  logic [DATA_WIDTH-1:0]           bias_mem [MAX_ROWS];
  logic [DATA_WIDTH-1:0]           out_buf  [MAX_ROWS];
  logic                            accept, handshake;
  logic [DATA_WIDTH-1:0]           bias_cur;
  logic signed [SW-1:0]            row_sum;
  logic [DATA_WIDTH-1:0]           row_elem;
  logic                            row_sat;
  logic [AW-1:0]                   load_base;
  logic [DATA_WIDTH*BANDWIDTH-1:0] load_data;
  logic                            load_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    handshake  = 1'b0;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) next_state = (num_rows == '0) ? DONE : COLLECT;
      COLLECT: if (result_valid_in) begin
        accept = 1'b1;
        if (row_cnt + RW'(1) == rows_total) next_state = DRAIN;
      end
      DRAIN:   if (out_valid && out_ready) begin
        handshake = 1'b1;
        if (out_last) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bias is placed on the product's binary point before the rounding stage.
  assign bias_cur = bias_mem[row_cnt[AW-1:0]];
  assign row_sum  = {{2{result_in[2*DATA_WIDTH-1]}}, result_in}
                  + {{(SW-DATA_WIDTH-FRAC_BITS){bias_cur[DATA_WIDTH-1]}}, bias_cur, {FRAC_BITS{1'b0}}};

  fxp_round_sat #(
    .IN_WIDTH (SW),
    .OUT_WIDTH(DATA_WIDTH),
    .FRAC_BITS(FRAC_BITS)
  ) u_round (
    .value_in (row_sum),
    .value_out(row_elem),
    .sat      (row_sat)
  );

  // The first chunk loads on the same edge that writes the last row, so that row bypasses the buffer.
  always_comb begin
    load_base = (state == DRAIN) ? out_base_addr + AW'(BANDWIDTH) : '0;
    load_data = '0;
    for (int i = 0; i < BANDWIDTH; i++) begin
      if (RW'(load_base) + RW'(i) < rows_total) begin
        if (accept && (RW'(load_base) + RW'(i) == row_cnt))
          load_data[i*DATA_WIDTH +: DATA_WIDTH] = row_elem;
        else
          load_data[i*DATA_WIDTH +: DATA_WIDTH] = out_buf[AW'(load_base + AW'(i))];
      end
    end
    load_last = (RW'(load_base) + RW'(BANDWIDTH) >= rows_total);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt       <= '0;
      rows_total    <= '0;
      out_data      <= '0;
      out_base_addr <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      sat_flag      <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        row_cnt       <= '0;
        out_base_addr <= '0;
        sat_flag      <= 1'b0;
        rows_total    <= (num_rows > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : num_rows;
      end
      if (accept) begin
        row_cnt <= row_cnt + RW'(1);
        if (row_sat) sat_flag <= 1'b1;
      end
      if ((accept && next_state == DRAIN) || (handshake && !out_last)) begin
        out_data      <= load_data;
        out_base_addr <= load_base;
        out_last      <= load_last;
        out_valid     <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MAX_ROWS; r++) bias_mem[r] <= '0;
    end else if (bias_write_enable) begin
      for (int i = 0; i < BANDWIDTH; i++)
        bias_mem[AW'(bias_base_addr + AW'(i))] <= bias_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MAX_ROWS; r++) out_buf[r] <= '0;
    end else if (accept) begin
      out_buf[row_cnt[AW-1:0]] <= row_elem;
    end
  end

endmodule
